// File: rtl/pipeline_ctrl.sv
// Pipeline hazard and redirect controller: builds the per-stage stall vector,
// sequences exception/ERET flushes around outstanding bus traffic, counts stalled cycles.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             inst_busy_i,
  input  logic             load_use_i,
  input  logic             exe_busy_i,
  input  logic             data_busy_i,
  input  logic             exc_req_i,
  input  logic             eret_req_i,
  input  logic [31:0]      epc_i,
  input  logic             perf_clear_i,
  output logic [3:0]       stall_o,
  output logic             flush_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_BUS = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_target;
  logic             r_flush;
  logic             r_redirect_valid;
  logic [31:0]      r_redirect_pc;
  logic [CNT_W-1:0] r_stall_cycles;

  logic             w_bus_busy;
  logic             w_req;
  logic [31:0]      w_new_target;
  logic [3:0]       w_stall;

  assign w_bus_busy   = inst_busy_i | data_busy_i;
  assign w_req        = exc_req_i | eret_req_i;
  assign w_new_target = exc_req_i ? EXC_VECTOR : epc_i;

  // Stall vector: each stage also stalls when any later stage does.
  always_comb begin
    w_stall = 4'b0000;
    if (!reset_i) begin
      case (r_state)
        RUN: begin
          w_stall[3] = data_busy_i;
          w_stall[2] = w_stall[3] | exe_busy_i;
          w_stall[1] = w_stall[2] | load_use_i;
          w_stall[0] = w_stall[1] | inst_busy_i;
        end
        WAIT_BUS: w_stall = 4'b1111;
        default:  w_stall = 4'b0000;
      endcase
    end
  end

  // Redirect sequencer; flush/redirect outputs are registered on entry to FLUSH.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state          <= RUN;
      r_target         <= 32'h0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'h0;
    end else begin
      case (r_state)
        RUN: begin
          r_flush          <= 1'b0;
          r_redirect_valid <= 1'b0;
          if (w_req) begin
            r_target <= w_new_target;
            if (w_bus_busy) begin
              r_state <= WAIT_BUS;
            end else begin
              r_state          <= FLUSH;
              r_flush          <= 1'b1;
              r_redirect_valid <= 1'b1;
              r_redirect_pc    <= w_new_target;
            end
          end
        end
        WAIT_BUS: begin
          r_flush          <= 1'b0;
          r_redirect_valid <= 1'b0;
          if (!w_bus_busy) begin
            r_state          <= FLUSH;
            r_flush          <= 1'b1;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= r_target;
          end
        end
        default: begin
          r_state          <= RUN;
          r_flush          <= 1'b0;
          r_redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating stalled-cycle counter; clear wins over increment.
  always_ff @(posedge clock_i) begin
    if (reset_i || perf_clear_i) begin
      r_stall_cycles <= '0;
    end else if ((w_stall != 4'b0000) && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_o          = w_stall;
  assign flush_o          = r_flush;
  assign redirect_valid_o = r_redirect_valid;
  assign redirect_pc_o    = r_redirect_pc;
  assign stall_cycles_o   = r_stall_cycles;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'hBFC00380, is the redirect target for exceptions.
REQ-002 Parameter CNT_W, default 16, is the width of the stall-cycle counter.
REQ-003 clock_i  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 reset_i  input  1  is the reset: synchronous, active-high.
REQ-005 inst_busy_i  input  1  indicates an instruction-bus fetch is outstanding.
REQ-006 load_use_i  input  1  indicates an ID-stage load-use hazard.
REQ-007 exe_busy_i  input  1  indicates a multi-cycle EXE operation (mul/div) is in progress.
REQ-008 data_busy_i  input  1  indicates a data-bus access is outstanding in MEM.
REQ-009 exc_req_i  input  1  is an exception raised by the MEM stage.
REQ-010 eret_req_i  input  1  is an ERET committing in the MEM stage.
REQ-011 epc_i  input  32  is the current CP0 EPC, used as the ERET target.
REQ-012 perf_clear_i  input  1  clears the stall counter.
REQ-013 stall_o  output  4  is the stall vector: bit0 inst, bit1 id, bit2 exe, bit3 data; it drives the stall_i ports of all pipeline registers.
REQ-014 flush_o  output  1  flushes all pipeline registers; it drives the exception_i ports.
REQ-015 redirect_valid_o  output  1  is a one-cycle PC redirect strobe.
REQ-016 redirect_pc_o  output  32  is the redirect target.
REQ-017 stall_cycles_o  output  CNT_W  is the saturating count of stalled cycles.

Function
REQ-018 The FSM SHALL have three states: RUN, WAIT_BUS and FLUSH.
REQ-019 In RUN, stall_o SHALL be combinational from the inputs:
- s3 = data_busy_i
- s2 = s3 | exe_busy_i
- s1 = s2 | load_use_i
- s0 = s1 | inst_busy_i
REQ-020 In RUN, exc_req_i=1 SHALL latch target=EXC_VECTOR; otherwise eret_req_i=1 SHALL latch target=epc_i; exc_req_i SHALL take priority when both are high.
REQ-021 On an accepted request in RUN, the next state SHALL be WAIT_BUS if inst_busy_i|data_busy_i, else FLUSH.
REQ-022 In WAIT_BUS, stall_o SHALL be 4'b1111; the FSM SHALL move to FLUSH on the first cycle in which inst_busy_i=0 and data_busy_i=0.
REQ-023 In FLUSH, the FSM SHALL hold exactly one cycle, then return to RUN.
REQ-024 In FLUSH, the outputs SHALL be: flush_o=1, redirect_valid_o=1, redirect_pc_o=latched target, stall_o=4'b0000.
REQ-025 Outside FLUSH, flush_o and redirect_valid_o SHALL be 0; redirect_pc_o SHALL hold its last value.
REQ-026 exc_req_i and eret_req_i SHALL be ignored in WAIT_BUS and FLUSH; no second request is queued.
REQ-027 Latency from an accepted request with idle buses to flush_o=1 SHALL be 1 cycle.
REQ-028 stall_cycles_o SHALL increment each cycle in which stall_o!=0, and SHALL saturate at all-ones without wrapping.
REQ-029 perf_clear_i SHALL set stall_cycles_o to 0 that cycle and SHALL take priority over the increment.
REQ-030 load_use_i and exe_busy_i SHALL NOT delay the WAIT_BUS-to-FLUSH transition; only the bus-busy inputs do.

Reset
REQ-031 reset_i=1 at a clock edge SHALL force the following, overriding all other inputs:
- state=RUN
- flush_o=0, redirect_valid_o=0
- redirect_pc_o=0, latched target=0
- stall_cycles_o=0
REQ-032 reset_i asserted in WAIT_BUS or FLUSH SHALL discard the pending redirect; no flush_o pulse SHALL follow reset.
REQ-033 While in reset, stall_o SHALL be 4'b0000.

Verification
REQ-034 Scenario: exe_busy_i=1 for 5 cycles, others 0 -> stall_o=4'b0111 for 5 cycles; stall_cycles_o=5.
REQ-035 Scenario: exc_req_i pulse with buses idle -> next cycle flush_o=1, redirect_valid_o=1, redirect_pc_o=32'hBFC00380; RUN the cycle after.
REQ-036 Scenario: eret_req_i with epc_i=32'h8000_1234 and data_busy_i=1 for 3 more cycles -> stall_o=4'b1111 for 3 cycles, then one FLUSH cycle with redirect_pc_o=32'h8000_1234.
REQ-037 Scenario: exc_req_i and eret_req_i simultaneous -> redirect_pc_o=EXC_VECTOR; a second exc_req_i during WAIT_BUS yields no extra flush.
REQ-038 Scenario: reset_i=1 in WAIT_BUS -> RUN next cycle, no flush_o, stall_cycles_o=0.
REQ-039 Scenario: CNT_W=4 with continuous stall for 20 cycles -> stall_cycles_o=4'hF; perf_clear_i=1 -> 0 next cycle.
